// File: rtl/gpio_in_filter.sv
// gpio_in_filter: input conditioning for the pins of one IO connector.
// Per pin: 2-FF synchroniser -> optional debounce filter clocked by a shared
// prescaler tick -> optional inversion -> edge pulses, sticky edge latches
// and a combined interrupt.
// Build option GPIO_IN_IRQ_MASK_EN: adds irq_mask, which gates latches into
// irq only; the latches themselves always set regardless of the mask.
module gpio_in_filter #(
    parameter int IOWidth   = 36,
    parameter int FiltWidth = 8,
    parameter int PreWidth  = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [IOWidth-1:0]   gpio_in,
    input  logic [IOWidth-1:0]   filt_en,
    input  logic [IOWidth-1:0]   invert,
    input  logic [PreWidth-1:0]  prescale,
    input  logic [FiltWidth-1:0] filt_count,
    input  logic [IOWidth-1:0]   rise_mask,
    input  logic [IOWidth-1:0]   fall_mask,
    input  logic [IOWidth-1:0]   latch_clr,
`ifdef GPIO_IN_IRQ_MASK_EN
    input  logic [IOWidth-1:0]   irq_mask,
`endif
    output logic [IOWidth-1:0]   data_out,
    output logic [IOWidth-1:0]   rise_ev,
    output logic [IOWidth-1:0]   fall_ev,
    output logic [IOWidth-1:0]   edge_latch,
    output logic                 irq
);

    // Debounce counter increment, holding at all-ones.
    function automatic logic [FiltWidth-1:0] sat_inc(input logic [FiltWidth-1:0] v);
        return (&v) ? v : v + FiltWidth'(1);
    endfunction

    // True once this mismatching tick brings the count up to the threshold.
    // Evaluated one bit wider so a saturated counter can never wrap below it.
    function automatic logic count_reached(input logic [FiltWidth-1:0] cnt,
                                           input logic [FiltWidth-1:0] thresh);
        return ({1'b0, cnt} + (FiltWidth+1)'(1)) >= {1'b0, thresh};
    endfunction

    logic [IOWidth-1:0]   sync_p0;
    logic [IOWidth-1:0]   sync_p1;
    logic [IOWidth-1:0]   filt_q;
    logic [IOWidth-1:0]   filt_nxt;
    logic [FiltWidth-1:0] cnt_q   [IOWidth];
    logic [FiltWidth-1:0] cnt_nxt [IOWidth];
    logic [PreWidth-1:0]  pre_cnt;
    logic                 tick;
    logic [FiltWidth-1:0] thresh;
    logic [IOWidth-1:0]   dout_nxt;
    logic [IOWidth-1:0]   irq_src;

    // ---- stage p0/p1: two-flop synchroniser on the raw pad levels
    // Capture asynchronous pad levels into the clk domain.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_p0 <= '0;
            sync_p1 <= '0;
        end else begin
            sync_p0 <= gpio_in;
            sync_p1 <= sync_p0;
        end
    end

    // Shared prescaler: ticks when it reaches zero and reloads, so a new
    // prescale value only takes effect at the next reload.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pre_cnt <= '0;
        end else if (tick) begin
            pre_cnt <= prescale;
        end else begin
            pre_cnt <= pre_cnt - PreWidth'(1);
        end
    end

    assign tick = (pre_cnt == '0);

    // ---- stage p2: filter decision, inversion and edge detection
    // Next filtered level and debounce count per pin; a bypassed pin keeps
    // its counter at zero, so re-enabling the filter always starts fresh.
    always_comb begin
        thresh = (filt_count == '0) ? FiltWidth'(1) : filt_count;
        for (int i = 0; i < IOWidth; i++) begin
            filt_nxt[i] = filt_q[i];
            cnt_nxt[i]  = cnt_q[i];
            if (!filt_en[i]) begin
                filt_nxt[i] = sync_p1[i];
                cnt_nxt[i]  = '0;
            end else if (tick) begin
                if (sync_p1[i] == filt_q[i]) begin
                    cnt_nxt[i] = '0;
                end else if (count_reached(cnt_q[i], thresh)) begin
                    filt_nxt[i] = sync_p1[i];
                    cnt_nxt[i]  = '0;
                end else begin
                    cnt_nxt[i] = sat_inc(cnt_q[i]);
                end
            end
        end
        dout_nxt = filt_nxt ^ invert;
    end

    // Register filtered level, output level and the matching edge pulses in
    // the same edge, so an edge pulse coincides with the data_out change.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            filt_q   <= '0;
            cnt_q    <= '{default: '0};
            data_out <= '0;
            rise_ev  <= '0;
            fall_ev  <= '0;
        end else begin
            filt_q   <= filt_nxt;
            cnt_q    <= cnt_nxt;
            data_out <= dout_nxt;
            rise_ev  <= dout_nxt & ~data_out;
            fall_ev  <= ~dout_nxt & data_out;
        end
    end

`ifdef GPIO_IN_IRQ_MASK_EN
    assign irq_src = edge_latch & irq_mask;
`else
    assign irq_src = edge_latch;
`endif

    // ---- stage p3: sticky latches, then the combined interrupt
    // Latch masked edge pulses; a set in the same cycle as a clear wins.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            edge_latch <= '0;
            irq        <= 1'b0;
        end else begin
            edge_latch <= (edge_latch & ~latch_clr)
                        | (rise_ev & rise_mask)
                        | (fall_ev & fall_mask);
            irq        <= |irq_src;
        end
    end

endmodule

// File: tb/tb_gpio_in_filter.sv
// Testbench for gpio_in_filter: directed stimulus pushes expected values,
// tagged with the cycle they are due, into a scoreboard queue; a monitor
// process compares them against the DUT outputs on the falling edge.
module tb_gpio_in_filter;

    localparam int IOW = 36;
    localparam int FW  = 8;
    localparam int PW  = 16;

    localparam int SIG_DOUT  = 0;
    localparam int SIG_RISE  = 1;
    localparam int SIG_FALL  = 2;
    localparam int SIG_LATCH = 3;
    localparam int SIG_IRQ   = 4;

    logic            clk;
    logic            reset_n;
    logic [IOW-1:0]  gpio_in;
    logic [IOW-1:0]  filt_en;
    logic [IOW-1:0]  invert;
    logic [PW-1:0]   prescale;
    logic [FW-1:0]   filt_count;
    logic [IOW-1:0]  rise_mask;
    logic [IOW-1:0]  fall_mask;
    logic [IOW-1:0]  latch_clr;
    logic [IOW-1:0]  data_out;
    logic [IOW-1:0]  rise_ev;
    logic [IOW-1:0]  fall_ev;
    logic [IOW-1:0]  edge_latch;
    logic            irq;
`ifdef GPIO_IN_IRQ_MASK_EN
    logic [IOW-1:0]  irq_mask;
`endif

    gpio_in_filter #(.IOWidth(IOW), .FiltWidth(FW), .PreWidth(PW)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .gpio_in    (gpio_in),
        .filt_en    (filt_en),
        .invert     (invert),
        .prescale   (prescale),
        .filt_count (filt_count),
        .rise_mask  (rise_mask),
        .fall_mask  (fall_mask),
        .latch_clr  (latch_clr),
`ifdef GPIO_IN_IRQ_MASK_EN
        .irq_mask   (irq_mask),
`endif
        .data_out   (data_out),
        .rise_ev    (rise_ev),
        .fall_ev    (fall_ev),
        .edge_latch (edge_latch),
        .irq        (irq)
    );

    typedef struct {
        int             cyc;
        int             sig;
        int             b;     // bit index, or -1 for a whole-vector compare
        logic [IOW-1:0] v;
        string          nm;
    } exp_t;

    exp_t exp_q[$];
    int   cyc   = 0;
    int   total = 0;
    int   bad   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [IOW-1:0] sig_val(input int s);
        case (s)
            SIG_DOUT:  return data_out;
            SIG_RISE:  return rise_ev;
            SIG_FALL:  return fall_ev;
            SIG_LATCH: return edge_latch;
            SIG_IRQ:   return {{(IOW-1){1'b0}}, irq};
            default:   return '0;
        endcase
    endfunction

    task automatic sb_push(input int at, input int sig, input int b,
                           input logic [IOW-1:0] v, input string nm);
        exp_t e;
        e.cyc = at; e.sig = sig; e.b = b; e.v = v; e.nm = nm;
        exp_q.push_back(e);
    endtask

    task automatic check(input exp_t e);
        logic [IOW-1:0] got;
        logic [IOW-1:0] want;
        got  = sig_val(e.sig);
        want = e.v;
        if (e.b >= 0) begin
            got  = {{(IOW-1){1'b0}}, got[e.b]};
            want = {{(IOW-1){1'b0}}, e.v[0]};
        end
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%h want=%h", e.nm, cyc, got, want);
        end
    endtask

    // Monitor: compare every scoreboard entry that is due this cycle.
    always @(negedge clk) begin
        for (int i = exp_q.size() - 1; i >= 0; i--) begin
            if (exp_q[i].cyc == cyc) begin
                check(exp_q[i]);
                exp_q.delete(i);
            end
        end
    end

    task automatic goto(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog cyc=%0d got=timeout want=finish", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int c;
        reset_n    = 1'b0;
        gpio_in    = '1;
        filt_en    = '0;
        invert     = '0;
        prescale   = '0;
        filt_count = '0;
        rise_mask  = '0;
        fall_mask  = '0;
        latch_clr  = '0;
`ifdef GPIO_IN_IRQ_MASK_EN
        irq_mask   = '1;
`endif
        @(negedge clk);

        // Reset held with pads high: everything reads zero.
        c = cyc;
        sb_push(c+1, SIG_DOUT,  -1, '0, "rst_dout");
        sb_push(c+1, SIG_RISE,  -1, '0, "rst_rise");
        sb_push(c+1, SIG_FALL,  -1, '0, "rst_fall");
        sb_push(c+1, SIG_LATCH, -1, '0, "rst_latch");
        sb_push(c+1, SIG_IRQ,   -1, '0, "rst_irq");
        goto(c+2);

        // Release: bypass pins follow two edges after s1 captures.
        c = cyc;
        reset_n = 1'b1;
        sb_push(c+2, SIG_DOUT,  -1, '0, "rel_dout_early");
        sb_push(c+3, SIG_DOUT,  -1, '1, "rel_dout");
        sb_push(c+3, SIG_RISE,  -1, '1, "rel_rise");
        sb_push(c+4, SIG_RISE,  -1, '0, "rel_rise_end");
        sb_push(c+5, SIG_LATCH, -1, '0, "rel_no_latch");
        sb_push(c+6, SIG_IRQ,   -1, '0, "rel_no_irq");
        goto(c+6);

        c = cyc;
        gpio_in = '0;
        sb_push(c+3, SIG_DOUT, -1, '0, "all_low_dout");
        sb_push(c+3, SIG_FALL, -1, '1, "all_low_fall");
        goto(c+6);

        // Bypass latency on pin 3.
        c = cyc;
        gpio_in[3] = 1'b1;
        sb_push(c+2, SIG_DOUT, 3, 1'b0, "byp_dout_k1");
        sb_push(c+3, SIG_DOUT, 3, 1'b1, "byp_dout_k2");
        sb_push(c+3, SIG_RISE, 3, 1'b1, "byp_rise");
        sb_push(c+3, SIG_FALL, 3, 1'b0, "byp_no_fall");
        sb_push(c+4, SIG_RISE, 3, 1'b0, "byp_rise_end");
        goto(c+6);

        // Filter on pin 5, prescale=0, filt_count=4.
        prescale   = '0;
        filt_count = 8'd4;
        filt_en[5] = 1'b1;
        goto(cyc+3);

        // 3-cycle glitch is rejected.
        c = cyc;
        gpio_in[5] = 1'b1;
        sb_push(c+5, SIG_DOUT, 5, 1'b0, "glitch_dout_a");
        sb_push(c+6, SIG_DOUT, 5, 1'b0, "glitch_dout_b");
        sb_push(c+8, SIG_DOUT, 5, 1'b0, "glitch_dout_c");
        sb_push(c+6, SIG_RISE, 5, 1'b0, "glitch_no_rise");
        goto(c+3);
        gpio_in[5] = 1'b0;
        goto(c+10);

        // 6-cycle pulse passes at k+5, falls four ticks after s2 drops.
        c = cyc;
        gpio_in[5] = 1'b1;
        sb_push(c+5,  SIG_DOUT, 5, 1'b0, "filt_dout_pre");
        sb_push(c+6,  SIG_DOUT, 5, 1'b1, "filt_dout_up");
        sb_push(c+6,  SIG_RISE, 5, 1'b1, "filt_rise");
        sb_push(c+11, SIG_DOUT, 5, 1'b1, "filt_dout_hold");
        sb_push(c+12, SIG_DOUT, 5, 1'b0, "filt_dout_down");
        sb_push(c+12, SIG_FALL, 5, 1'b1, "filt_fall");
        goto(c+6);
        gpio_in[5] = 1'b0;
        goto(c+15);

        // Prescaled filter: prescale=9 ticks at c+1, c+11, c+21, ...
        c = cyc;
        prescale   = 16'd9;
        filt_count = 8'd2;
        gpio_in[5] = 1'b1;
        sb_push(c+20, SIG_DOUT, 5, 1'b0, "pre_dout_pre");
        sb_push(c+21, SIG_DOUT, 5, 1'b1, "pre_dout_up");
        sb_push(c+21, SIG_RISE, 5, 1'b1, "pre_rise");
        // One mismatching tick, revert, then a fresh change needs two ticks.
        sb_push(c+51, SIG_DOUT, 5, 1'b1, "revert_hold_a");
        sb_push(c+60, SIG_DOUT, 5, 1'b1, "revert_hold_b");
        sb_push(c+61, SIG_DOUT, 5, 1'b0, "revert_dout_down");
        sb_push(c+61, SIG_FALL, 5, 1'b1, "revert_fall");
        goto(c+25);
        gpio_in[5] = 1'b0;
        goto(c+33);
        gpio_in[5] = 1'b1;
        goto(c+45);
        gpio_in[5] = 1'b0;
        goto(c+62);
        prescale = '0;
        goto(c+75);

        // Latch and irq on pin 7.
        c = cyc;
        rise_mask[7] = 1'b1;
        gpio_in[7]   = 1'b1;
        sb_push(c+3,  SIG_RISE,  7, 1'b1, "lat_rise");
        sb_push(c+3,  SIG_LATCH, 7, 1'b0, "lat_pre");
        sb_push(c+4,  SIG_LATCH, 7, 1'b1, "lat_set");
        sb_push(c+4,  SIG_IRQ,   0, 1'b0, "irq_lag");
        sb_push(c+5,  SIG_IRQ,   0, 1'b1, "irq_set");
        sb_push(c+12, SIG_RISE,  7, 1'b1, "lat_rise2");
        sb_push(c+13, SIG_LATCH, 7, 1'b1, "lat_set_wins");
        sb_push(c+14, SIG_LATCH, 7, 1'b1, "lat_set_wins_hold");
        sb_push(c+14, SIG_IRQ,   0, 1'b1, "irq_hold");
        sb_push(c+16, SIG_LATCH, 7, 1'b1, "lat_before_clr");
        sb_push(c+17, SIG_LATCH, 7, 1'b0, "lat_cleared");
        sb_push(c+17, SIG_IRQ,   0, 1'b1, "irq_clr_lag");
        sb_push(c+18, SIG_IRQ,   0, 1'b0, "irq_cleared");
        goto(c+5);
        gpio_in[7] = 1'b0;
        goto(c+9);
        gpio_in[7] = 1'b1;
        goto(c+12);
        latch_clr[7] = 1'b1;
        goto(c+13);
        latch_clr[7] = 1'b0;
        goto(c+16);
        latch_clr[7] = 1'b1;
        goto(c+17);
        latch_clr[7] = 1'b0;
        goto(c+20);

        // Invert toggle on steady-low pin 2, only fall_mask set.
        c = cyc;
        fall_mask[2] = 1'b1;
        invert[2]    = 1'b1;
        sb_push(c+1, SIG_DOUT,  2, 1'b1, "inv_dout");
        sb_push(c+1, SIG_RISE,  2, 1'b1, "inv_rise");
        sb_push(c+1, SIG_FALL,  2, 1'b0, "inv_no_fall");
        sb_push(c+2, SIG_RISE,  2, 1'b0, "inv_rise_end");
        sb_push(c+2, SIG_LATCH, 2, 1'b0, "inv_no_latch_a");
        sb_push(c+3, SIG_LATCH, 2, 1'b0, "inv_no_latch_b");
        goto(c+5);

        // Reset mid-operation clears levels and latches.
        c = cyc;
        reset_n = 1'b0;
        sb_push(c+1, SIG_DOUT,  -1, '0, "mid_rst_dout");
        sb_push(c+1, SIG_LATCH, -1, '0, "mid_rst_latch");
        sb_push(c+1, SIG_IRQ,   -1, '0, "mid_rst_irq");
        goto(c+3);
        reset_n = 1'b1;
        goto(c+8);

        foreach (exp_q[i]) begin
            total++;
            bad++;
            $display("FAIL %s cyc=%0d got=unchecked want=due_at_%0d",
                     exp_q[i].nm, cyc, exp_q[i].cyc);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/gpio_in_filter.md
Name: gpio_in_filter

Overview:
- Input-direction companion to the bidirectional GPIO pin mux: conditions raw pad levels before they reach host-visible registers and function inputs.
- Per-pin processing chain:
  - 2-FF synchroniser
  - optional glitch filter driven by a shared prescaler
  - optional inversion
  - edge detection, with sticky edge latches and a combined interrupt
- Sits between the pad ring and the register file / function-select fabric; one instance covers one IO connector.

Parameters:
- IOWidth, 36, number of pins handled.
- FiltWidth, 8, width of per-pin debounce counter and of filt_count.
- PreWidth, 16, width of the shared prescaler and of prescale.

Ports:
- clk  input  1  single system clock; all logic on rising edge.
- reset_n  input  1  asynchronous active-low reset.
- gpio_in  input  IOWidth  raw pad levels, asynchronous to clk.
- filt_en  input  IOWidth  per-pin filter enable; 0 = bypass filter.
- invert  input  IOWidth  per-pin polarity invert, applied after filtering.
- prescale  input  PreWidth  filter tick period minus one.
- filt_count  input  FiltWidth  consecutive mismatching ticks required to accept a new level.
- rise_mask  input  IOWidth  per-pin: latch rising edges.
- fall_mask  input  IOWidth  per-pin: latch falling edges.
- latch_clr  input  IOWidth  write-1-to-clear pulse for edge_latch.
- data_out  output  IOWidth  conditioned pin levels.
- rise_ev  output  IOWidth  1-cycle pulse on a data_out 0->1 transition.
- fall_ev  output  IOWidth  1-cycle pulse on a data_out 1->0 transition.
- edge_latch  output  IOWidth  sticky edge flags.
- irq  output  1  OR of latched edges.

Behaviour:
- Reset (reset_n low, asynchronous): sync stages, filtered levels, debounce counters, prescaler, data_out, rise_ev, fall_ev, edge_latch and irq all go to 0. Deassertion is consumed synchronously; the first active edge follows.
- Reset mid-operation discards every partial debounce count and latch, with no spurious edge on release.
- Synchroniser: gpio_in sampled to s1, then s2. Let edge k be the first edge where s1 holds the new value.
- Prescaler:
  - Down-counter loaded with prescale; asserts tick when it equals 0, then reloads.
  - prescale=0 gives tick every clk.
  - A change of prescale takes effect at the next reload.
- Per-pin filtered register f (bypass, filt_en=0): f <= s2 every clk. data_out reflects the new level at edge k+2.
- Per-pin filtered register f (filter, filt_en=1):
  - On tick with s2==f: counter <= 0.
  - On tick with s2!=f and counter+1 >= filt_count: f <= s2, counter <= 0.
  - On tick with s2!=f otherwise: counter++, saturating at all-ones.
  - No tick: counter holds.
  - filt_count=0 behaves as 1.
  - With prescale=0 and filt_count=N, a stable change reaches data_out at edge k+1+N.
  - Pulses shorter than N ticks are rejected.
  - Comparison is >=, so lowering filt_count on the fly never wedges a counter.
- Toggling filt_en on a pin: counter cleared; f continues from its current value.
- Output level: data_out = f XOR invert, registered in the same edge that updates f. An invert toggle alone produces an edge event one cycle later; that is legal and specified.
- Edge pulses:
  - rise_ev/fall_ev are registered, asserted in the cycle data_out changes, for exactly 1 clk.
  - Never both high on one pin.
- Edge latches:
  - Set when (rise_ev & rise_mask) | (fall_ev & fall_mask).
  - Cleared by latch_clr.
  - Set and clear on the same pin in the same cycle: set wins.
- irq: registered OR-reduction of edge_latch; lags edge_latch by 1 clk; deasserts 1 clk after the last latch clears.

Optional Feature:
- Macro GPIO_IN_IRQ_MASK_EN.
- When defined: extra input irq_mask [IOWidth], and irq = registered OR of (edge_latch & irq_mask). Latches still set regardless of mask.
- When undefined: no irq_mask port; irq = registered OR of edge_latch.

Test Plan:
- Reset: drive gpio_in all-ones, hold reset_n low. Expect all outputs 0. Release reset: bypass pins show data_out=1 two edges after s1 captures, with rise_ev pulse; no latch set when masks are 0.
- Bypass latency: pin 3, filt_en=0, gpio_in[3] 0->1. Expect data_out[3]=1 at edge k+2; rise_ev[3] high 1 cycle.
- Filter: prescale=0, filt_count=4, pin 5 filtered.
  - 3-cycle high glitch: no change on data_out[5].
  - 6-cycle high: data_out[5]=1 at edge k+5, then back to 0 four ticks after the fall reaches s2.
- Prescaled filter: prescale=9, filt_count=2, stable change. Expect data_out update after 2 ticks (~20 clk). A mid-count level revert clears the counter with no output change.
- Latch/irq: rise_mask[7]=1. Rising edge gives edge_latch[7]=1, then irq=1 next cycle. latch_clr[7] coincident with a new rise edge: latch stays 1. A later lone clear: latch 0, irq 0 one cycle after.
- Invert: invert[2] 0->1 with gpio_in[2] steady 0. Expect data_out[2]=1 and rise_ev[2] pulse; with fall_mask only set, no latch.
